extslot: RTL and testbench

MSX secondary (extended) slot expander on the internal MSX-50BUS. It holds the secondary-slot select register at memory address FFFFh, answers reads of that register with the inverted value, and decodes each memory access into one of four sub-slot enables. It sits between the bus front-end and up to four memory devices that share one primary slot.

---
 rtl/extslot_pkg.sv | 20 ++
 rtl/extslot_if.sv | 33 +++
 rtl/extslot.sv | 59 +++++
 tb/tb_extslot.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/extslot_pkg.sv
// Shared MSX-50BUS constants and slot helpers.
// Imported by the extslot bus interface and the expander core.
package extslot_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  localparam logic [BUS_ADDR_W-1:0] EXTSLOT_REG_ADDR = 16'hFFFF;

  typedef logic [1:0] subslot_t;
  typedef logic [1:0] page_t;

  function automatic subslot_t page_field(
    input logic [7:0] sltsl,
    input page_t      page
  );
    return sltsl[{page, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/extslot_if.sv
// MSX-50BUS request/response bundle between the bus front-end
// (master) and a memory-mapped block such as the expander (slave).
interface extslot_if;
  import extslot_pkg::*;

  logic [BUS_ADDR_W-1:0] bus_address;
  logic [BUS_DATA_W-1:0] bus_write_data;
  logic [BUS_DATA_W-1:0] bus_read_data;
  logic                  bus_read;
  logic                  bus_write;
  logic                  bus_io;
  logic                  bus_memory;
  logic                  bus_io_cs;
  logic                  bus_memory_cs;
  logic                  bus_read_ready;

  modport master (
    output bus_address, bus_write_data,
    output bus_read, bus_write,
    output bus_io, bus_memory,
    input  bus_io_cs, bus_memory_cs,
    input  bus_read_ready, bus_read_data
  );

  modport slave (
    input  bus_address, bus_write_data,
    input  bus_read, bus_write,
    input  bus_io, bus_memory,
    output bus_io_cs, bus_memory_cs,
    output bus_read_ready, bus_read_data
  );

endinterface

// File: rtl/extslot.sv
// MSX secondary slot expander: FFFFh select register with inverted
// readback, and per-page decode of memory cycles into four sub-slots.
module extslot
  import extslot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  extslot_if.slave   bus,
  output logic       extslot_memory0,
  output logic       extslot_memory1,
  output logic       extslot_memory2,
  output logic       extslot_memory3
);

  logic [7:0] sltsl;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       reg_hit;
  logic       hit_rd;
  logic       hit_wr;
  logic [3:0] sel;

  assign reg_hit = bus.bus_memory &&
                   (bus.bus_address == EXTSLOT_REG_ADDR);
  assign hit_rd  = bus.bus_read  && reg_hit;
  assign hit_wr  = bus.bus_write && reg_hit;

  // Readback samples sltsl before a same-edge write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sltsl    <= 8'h00;
      rd_ready <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_ready <= hit_rd;
      rd_data  <= hit_rd ? ~sltsl : 8'h00;
      if (hit_wr)
        sltsl <= bus.bus_write_data;
    end
  end

  always_comb begin
    sel = 4'b0000;
    if (bus.bus_memory &&
        (bus.bus_address != EXTSLOT_REG_ADDR))
      sel[page_field(sltsl, bus.bus_address[15:14])] = 1'b1;
  end

  assign extslot_memory0 = sel[0];
  assign extslot_memory1 = sel[1];
  assign extslot_memory2 = sel[2];
  assign extslot_memory3 = sel[3];

  assign bus.bus_io_cs      = 1'b0;
  assign bus.bus_memory_cs  = 1'b1;
  assign bus.bus_read_ready = rd_ready;
  assign bus.bus_read_data  = rd_data;

endmodule

// File: tb/tb_extslot.sv
// Directed bench for extslot: register writes, inverted readback,
// sub-slot decode per page, ignored accesses and mid-read reset.
module tb_extslot;

  logic clk = 1'b0;
  logic reset;
  logic m0, m1, m2, m3;
  int   passed = 0;
  int   total  = 0;

  extslot_if bus ();

  extslot dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .extslot_memory0 (m0),
    .extslot_memory1 (m1),
    .extslot_memory2 (m2),
    .extslot_memory3 (m3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic idle();
    bus.bus_read       = 1'b0;
    bus.bus_write      = 1'b0;
    bus.bus_io         = 1'b0;
    bus.bus_memory     = 1'b0;
    bus.bus_address    = 16'h0000;
    bus.bus_write_data = 8'h00;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d,
                    input logic mem, input logic io);
    @(negedge clk);
    bus.bus_address    = a;
    bus.bus_write_data = d;
    bus.bus_memory     = mem;
    bus.bus_io         = io;
    bus.bus_write      = 1'b1;
    @(negedge clk);
    idle();
  endtask

  // exp is {m3,m2,m1,m0}
  task automatic dec(input string tag, input logic [15:0] a,
                     input logic mem, input logic [3:0] exp);
    @(negedge clk);
    bus.bus_address = a;
    bus.bus_memory  = mem;
    #1;
    chk(tag, {28'd0, m3, m2, m1, m0}, {28'd0, exp});
    idle();
  endtask

  task automatic dec4(input string tag, input logic [3:0] e0,
                      input logic [3:0] e1, input logic [3:0] e2,
                      input logic [3:0] e3);
    dec({tag, "_p0"}, 16'h0000, 1'b1, e0);
    dec({tag, "_p1"}, 16'h4000, 1'b1, e1);
    dec({tag, "_p2"}, 16'h8000, 1'b1, e2);
    dec({tag, "_p3"}, 16'hC000, 1'b1, e3);
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    @(negedge clk);
    bus.bus_address = 16'hFFFF;
    bus.bus_memory  = 1'b1;
    bus.bus_read    = 1'b1;
    @(posedge clk);
    #1 idle();
    chk({tag, "_rdy"}, {31'd0, bus.bus_read_ready}, 32'd1);
    chk({tag, "_dat"}, {24'd0, bus.bus_read_data}, {24'd0, exp});
    @(posedge clk);
    #1;
    chk({tag, "_rdy0"}, {31'd0, bus.bus_read_ready}, 32'd0);
    chk({tag, "_dat0"}, {24'd0, bus.bus_read_data}, 32'd0);
  endtask

  task automatic noresp(input string tag, input logic [15:0] a,
                        input logic mem, input logic io);
    logic seen;
    @(negedge clk);
    bus.bus_address = a;
    bus.bus_memory  = mem;
    bus.bus_io      = io;
    bus.bus_read    = 1'b1;
    @(posedge clk);
    #1 idle();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.bus_read_ready !== 1'b0 ||
          bus.bus_read_data !== 8'h00)
        seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, bus.bus_read_ready}, 32'd0);
    chk("rst_dat", {24'd0, bus.bus_read_data}, 32'd0);
    chk("io_cs", {31'd0, bus.bus_io_cs}, 32'd0);
    chk("mem_cs", {31'd0, bus.bus_memory_cs}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    dec4("rst", 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    dec("nomem", 16'h4000, 1'b0, 4'b0000);

    wr(16'hFFFF, 8'hE4, 1'b1, 1'b0);
    dec4("e4", 4'b0001, 4'b0010, 4'b0100, 4'b1000);
    wr(16'hFFFF, 8'h1B, 1'b1, 1'b0);
    dec4("1b", 4'b1000, 4'b0100, 4'b0010, 4'b0001);

    wr(16'hFFFF, 8'hE4, 1'b1, 1'b0);
    wr(16'h1234, 8'h00, 1'b1, 1'b0);
    wr(16'h4567, 8'h00, 1'b1, 1'b0);
    wr(16'h89AB, 8'h00, 1'b1, 1'b0);
    wr(16'h1234, 8'h00, 1'b0, 1'b1);
    wr(16'hFFFF, 8'h00, 1'b0, 1'b1);
    dec4("ign", 4'b0001, 4'b0010, 4'b0100, 4'b1000);
    dec("regaddr", 16'hFFFF, 1'b1, 4'b0000);
    dec("fffe", 16'hFFFE, 1'b1, 4'b1000);
    dec("nomem_e4", 16'hC000, 1'b0, 4'b0000);

    rd("rd_e4", 8'h1B);
    wr(16'hFFFF, 8'h1B, 1'b1, 1'b0);
    rd("rd_1b", 8'hE4);
    wr(16'hFFFF, 8'hFF, 1'b1, 1'b0);
    rd("rd_ff", 8'h00);
    wr(16'hFFFF, 8'h55, 1'b1, 1'b0);
    rd("rd_55", 8'hAA);

    // back-to-back reads of the register
    @(negedge clk);
    bus.bus_address = 16'hFFFF;
    bus.bus_memory  = 1'b1;
    bus.bus_read    = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_rdy1", {31'd0, bus.bus_read_ready}, 32'd1);
    @(posedge clk);
    #1 idle();
    chk("b2b_rdy2", {31'd0, bus.bus_read_ready}, 32'd1);
    chk("b2b_dat2", {24'd0, bus.bus_read_data}, 32'hAA);

    // simultaneous read and write: old value comes back
    wr(16'hFFFF, 8'hE4, 1'b1, 1'b0);
    @(negedge clk);
    bus.bus_address    = 16'hFFFF;
    bus.bus_memory     = 1'b1;
    bus.bus_read       = 1'b1;
    bus.bus_write      = 1'b1;
    bus.bus_write_data = 8'h55;
    @(posedge clk);
    #1 idle();
    chk("rw_rdy", {31'd0, bus.bus_read_ready}, 32'd1);
    chk("rw_dat", {24'd0, bus.bus_read_data}, 32'h1B);
    dec4("rw", 4'b0010, 4'b0010, 4'b0010, 4'b0010);

    noresp("nr_m1234", 16'h1234, 1'b1, 1'b0);
    noresp("nr_m89ab", 16'h89AB, 1'b1, 1'b0);
    noresp("nr_mfcc1", 16'hFCC1, 1'b1, 1'b0);
    noresp("nr_i1234", 16'h1234, 1'b0, 1'b1);
    noresp("nr_ifcc1", 16'hFCC1, 1'b0, 1'b1);
    noresp("nr_iffff", 16'hFFFF, 1'b0, 1'b1);

    // reset one cycle after a register read request
    wr(16'hFFFF, 8'hE4, 1'b1, 1'b0);
    @(negedge clk);
    bus.bus_address = 16'hFFFF;
    bus.bus_memory  = 1'b1;
    bus.bus_read    = 1'b1;
    @(posedge clk);
    #1 idle();
    reset = 1'b1;
    #1;
    chk("mid_rdy", {31'd0, bus.bus_read_ready}, 32'd0);
    chk("mid_dat", {24'd0, bus.bus_read_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rdy2", {31'd0, bus.bus_read_ready}, 32'd0);
    dec4("mid", 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    rd("mid_rd", 8'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
